seven_seg_scanner: RTL and testbench

Time-multiplexed driver for a NUM_DIGITS common-anode/cathode 7-segment display bank. It scans one digit per refresh slot and decodes BCD to segments internally. It also provides per-digit decimal points, optional leading-zero blanking, anti-ghosting blank time and tear-free frame-synchronous value updates. It sits between the BCD counters/ALU datapath and the board display pins.

---
 rtl/seven_seg_if.sv | 28 ++
 rtl/seven_seg_scanner.sv | 176 +++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_if.sv
// Signal bundle between the BCD datapath and the 7-segment scanner.
// master: drives en/load/digits_in/dp_in and observes the display outputs.
// slave: the scanner; consumes the controls and drives seg/an/idx/tick/busy.
interface seven_seg_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic [IDXW-1:0]         digit_idx;
    logic                    frame_tick;
    logic                    busy_pending;

    modport master (
        output en, load, digits_in, dp_in,
        input  seg_out, an_out, digit_idx, frame_tick, busy_pending
    );

    modport slave (
        input  en, load, digits_in, dp_in,
        output seg_out, an_out, digit_idx, frame_tick, busy_pending
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Purpose: time-multiplexed BCD 7-segment driver with leading-zero blanking,
//          anti-ghost blank time and frame-synchronous (tear-free) value updates.
// Latency: seg_out/an_out registered, one cycle behind digit_idx/prescaler.
// Backpressure: none; load is always accepted and parked until the frame wraps.
// Ports: clk, rst_n (async active-low); bus (slave): en, load, digits_in,
//        dp_in in; seg_out {a..g,dp}, an_out, digit_idx, frame_tick,
//        busy_pending out.
module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    seven_seg_if.slave  bus
);
    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW   = 4 * NUM_DIGITS;

    localparam logic [PW-1:0]         P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IDXW-1:0]       I_LAST = IDXW'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ?
                                                {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // BCD to {a,b,c,d,e,f,g}; non-decimal codes render dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_decode = 7'h7E;
            4'd1:    seg_decode = 7'h30;
            4'd2:    seg_decode = 7'h6D;
            4'd3:    seg_decode = 7'h79;
            4'd4:    seg_decode = 7'h33;
            4'd5:    seg_decode = 7'h5B;
            4'd6:    seg_decode = 7'h5F;
            4'd7:    seg_decode = 7'h70;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h7B;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    logic [PW-1:0]         prescaler_q, prescaler_d;
    logic [IDXW-1:0]       digit_idx_q, digit_idx_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  busy_q, busy_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  slot_end;
    logic                  frame_end;
    logic                  in_blank;
    logic                  zero_above;
    logic [NUM_DIGITS-1:0] lead_blank;
    logic [NUM_DIGITS-1:0] onehot;
    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic                  sel_blank;
    logic [7:0]            seg_raw;

    // Anti-ghost window: anodes stay dark for the first BLANK_CYCLES of a slot.
    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign in_blank = (prescaler_q < PW'(BLANK_CYCLES));
        end else begin : g_noblank
            assign in_blank = 1'b0;
        end
    endgenerate

    // Scan timing.
    always_comb begin
        slot_end    = bus.en && (prescaler_q == P_LAST);
        frame_end   = slot_end && (digit_idx_q == I_LAST);
        prescaler_d = prescaler_q;
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            prescaler_d = '0;
            digit_idx_d = (digit_idx_q == I_LAST) ? '0 : digit_idx_q + IDXW'(1);
        end else if (bus.en) begin
            prescaler_d = prescaler_q + PW'(1);
        end
    end

    // Leading-zero mask: digit i is dark when it and everything above is zero.
    always_comb begin
        zero_above = 1'b1;
        lead_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (disp_q[4*i +: 4] == 4'd0);
            lead_blank[i] = zero_above && (BLANK_LEADING != 0);
        end
    end

    // Current-digit selection and segment/anode next state.
    always_comb begin
        sel_nib   = 4'd0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        onehot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDXW'(i) == digit_idx_q) begin
                sel_nib   = disp_q[4*i +: 4];
                sel_dp    = disp_dp_q[i];
                sel_blank = lead_blank[i];
                onehot[i] = 1'b1;
            end
        end
        seg_raw = {(sel_blank ? 7'h00 : seg_decode(sel_nib)), sel_dp};
        // XOR with the off pattern applies the pin polarity in one step.
        seg_d = bus.en ? (seg_raw ^ SEG_OFF) : SEG_OFF;
        an_d  = (bus.en && !in_blank) ? (onehot ^ AN_OFF) : AN_OFF;
    end

    // Double-buffered update: the visible value only changes on a frame wrap.
    always_comb begin
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        pend_d    = pend_q;
        pend_dp_d = pend_dp_q;
        busy_d    = busy_q;
        if (bus.load) begin
            pend_d    = bus.digits_in;
            pend_dp_d = bus.dp_in;
        end
        if (frame_end) begin
            busy_d = 1'b0;
            // A load landing on the wrap bypasses pending so it is not a frame late.
            if (bus.load) begin
                disp_d    = bus.digits_in;
                disp_dp_d = bus.dp_in;
            end else if (busy_q) begin
                disp_d    = pend_q;
                disp_dp_d = pend_dp_q;
            end
        end else if (bus.load) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            digit_idx_q <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            busy_q      <= 1'b0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            prescaler_q <= prescaler_d;
            digit_idx_q <= digit_idx_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            busy_q      <= busy_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign bus.seg_out      = seg_q;
    assign bus.an_out       = an_q;
    assign bus.digit_idx    = digit_idx_q;
    assign bus.frame_tick   = frame_end;
    assign bus.busy_pending = busy_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;
    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [7:0] seg;
        logic [3:0] an;
        logic [1:0] idx;
        logic       ft;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: enabled-cycle count t gives slot position and digit.
    int          t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pend_dp;
    logic        m_busy;

    function automatic logic [7:0] ref_font(input logic [3:0] d);
        case (d)
            4'd0: return 8'hFC;  4'd1: return 8'h60;  4'd2: return 8'hDA;
            4'd3: return 8'hF2;  4'd4: return 8'h66;  4'd5: return 8'hB6;
            4'd6: return 8'hBE;  4'd7: return 8'hE0;  4'd8: return 8'hFE;
            4'd9: return 8'hF6;
            default: return 8'h00;
        endcase
    endfunction

    // Digit i is leading-zero blanked when the value shifted down by i digits is 0.
    function automatic logic [7:0] ref_seg(input logic [15:0] v, input logic [3:0] dpv,
                                           input int i);
        logic [15:0] upper;
        logic [3:0]  nib;
        upper = v >> (4 * i);
        nib   = upper[3:0];
        if (i > 0 && upper == 16'd0) return {7'd0, dpv[i]};
        return ref_font(nib) | {7'd0, dpv[i]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        t = 0; m_disp = '0; m_pend = '0; m_dp = '0; m_pend_dp = '0; m_busy = 1'b0;
    endtask

    // Drive one clock of stimulus and queue what the DUT must show after the edge.
    task automatic cycle(input logic e, input logic ld, input logic [15:0] d,
                         input logic [3:0] p);
        exp_t x;
        int   pos, dig;
        logic wrap;
        @(negedge clk);
        bus.en = e; bus.load = ld; bus.digits_in = d; bus.dp_in = p;
        pos  = t % DIV;
        dig  = (t / DIV) % N;
        wrap = e && pos == DIV - 1 && dig == N - 1;
        x.seg = e ? ref_seg(m_disp, m_dp, dig) : 8'h00;
        x.an  = (e && pos >= BLANK) ? ~(4'b0001 << dig) : 4'hF;
        if (wrap) begin
            if (ld) begin m_disp = d; m_dp = p; end
            else if (m_busy) begin m_disp = m_pend; m_dp = m_pend_dp; end
            m_busy = 1'b0;
        end else if (ld) begin
            m_pend = d; m_pend_dp = p; m_busy = 1'b1;
        end
        if (e) t++;
        x.idx  = 2'((t / DIV) % N);
        x.busy = m_busy;
        x.ft   = e && (t % DIV == DIV - 1) && ((t / DIV) % N == N - 1);
        q.push_back(x);
    endtask

    task automatic idle(input int n, input logic e);
        for (int k = 0; k < n; k++) cycle(e, 1'b0, 16'h0, 4'h0);
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        int r;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      v[4*k +: 4] = 4'd0;
            else if (r < 8) v[4*k +: 4] = 4'($urandom_range(0, 9));
            else            v[4*k +: 4] = 4'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 2) == 0) v = v >> (4 * $urandom_range(1, 3));
        return v;
    endfunction

    // Monitor: every clock where an expectation is queued, compare registered outputs.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("seg_out",      32'(bus.seg_out),      32'(x.seg));
                chk("an_out",       32'(bus.an_out),       32'(x.an));
                chk("digit_idx",    32'(bus.digit_idx),    32'(x.idx));
                chk("frame_tick",   32'(bus.frame_tick),   32'(x.ft));
                chk("busy_pending", 32'(bus.busy_pending), 32'(x.busy));
            end
        end
    end

    initial begin
        int guard;
        bus.en = 1'b0; bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg",  32'(bus.seg_out),      32'h00);
        chk("rst_an",   32'(bus.an_out),       32'hF);
        chk("rst_idx",  32'(bus.digit_idx),    32'h0);
        chk("rst_busy", 32'(bus.busy_pending), 32'h0);
        chk("rst_ft",   32'(bus.frame_tick),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        idle(10, 1'b1);
        cycle(1'b1, 1'b1, 16'h0305, 4'b0010);
        idle(40, 1'b1);
        cycle(1'b1, 1'b1, 16'h0000, 4'b0000);
        idle(40, 1'b1);
        cycle(1'b1, 1'b1, 16'h00A9, 4'b0000);
        idle(40, 1'b1);
        // Load exactly on the wrap cycle.
        while ((t % (DIV * N)) != DIV * N - 1) cycle(1'b1, 1'b0, 16'h0, 4'h0);
        cycle(1'b1, 1'b1, 16'h1234, 4'b0000);
        idle(40, 1'b1);
        // Back-to-back loads: last one wins.
        cycle(1'b1, 1'b1, 16'h0987, 4'b1111);
        cycle(1'b1, 1'b1, 16'h0042, 4'b0100);
        idle(40, 1'b1);

        for (int k = 0; k < 2500; k++)
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                  rand_digits(), 4'($urandom_range(0, 15)));

        // Park mid-slot with a pending value, then stall for 20 clocks.
        idle(1, 1'b1);
        while ((t % DIV) != 4 || (t % (DIV * N)) < DIV) cycle(1'b1, 1'b0, 16'h0, 4'h0);
        cycle(1'b1, 1'b1, 16'h0777, 4'b0001);
        idle(20, 1'b0);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_seg",  32'(bus.seg_out),      32'h00);
        chk("arst_an",   32'(bus.an_out),       32'hF);
        chk("arst_idx",  32'(bus.digit_idx),    32'h0);
        chk("arst_busy", 32'(bus.busy_pending), 32'h0);
        chk("arst_ft",   32'(bus.frame_tick),   32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // The discarded pending value must never appear.
        idle(70, 1'b1);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
